// File: rtl/cms_sample_feeder_if.sv
// Bundle of sample-source, CMS-engine and result-sink signals around the feeder.
// master is the feeder's view; slave is the view of the surrounding blocks.
interface cms_sample_feeder_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        log2n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_y;
    logic [DATA_W-1:0] in_y_hat;
    logic              cms_start;
    logic [2:0]        cms_log2n;
    logic [DATA_W-1:0] cms_y;
    logic [DATA_W-1:0] cms_y_hat;
    logic              cms_next_number;
    logic              cms_done;
    logic [63:0]       cms_result;
    logic              res_valid;
    logic              res_ready;
    logic [63:0]       res_data;
    logic              busy;
    logic              err;

    modport master (
        input  log2n, in_valid, in_y, in_y_hat, cms_next_number, cms_done, cms_result, res_ready,
        output in_ready, cms_start, cms_log2n, cms_y, cms_y_hat, res_valid, res_data, busy, err
    );

    modport slave (
        output log2n, in_valid, in_y, in_y_hat, cms_next_number, cms_done, cms_result, res_ready,
        input  in_ready, cms_start, cms_log2n, cms_y, cms_y_hat, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/cms_sample_feeder.sv
// Buffers one block of (y, y_hat) pairs, replays it to the CMS engine on
// next_number requests, and hands the CMS result downstream.
module cms_sample_feeder #(
    parameter int MAX_LOG2N = 7,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    cms_sample_feeder_if.master bus
);
    localparam int DEPTH = 1 << MAX_LOG2N;
    localparam int AW    = (MAX_LOG2N > 0) ? MAX_LOG2N : 1;
    localparam int CW    = MAX_LOG2N + 1;

    typedef enum logic [1:0] {LOAD, RUN, WAIT_DONE, RESULT} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       wr_cnt_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [2:0]          n_log_reg;
    logic                err_reg;
    logic [63:0]         res_data_reg;

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [2*DATA_W-1:0] rd_data_reg;

    logic [2:0]          log2n_clamped;
    logic [2:0]          n_cur;
    logic [CW-1:0]       load_pairs;
    logic [CW-1:0]       run_pairs;
    logic                accept;
    logic                load_last;
    logic                cms_active;
    logic                req;
    logic                advance;
    logic                consume_last;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [AW-1:0]       wr_addr;
    logic [2*DATA_W-1:0] wr_data;

    assign log2n_clamped = (int'(bus.log2n) > MAX_LOG2N) ? 3'(MAX_LOG2N) : bus.log2n;
    // The block size is taken live on the first write, from the latch afterwards.
    assign n_cur        = (wr_cnt_reg == '0) ? log2n_clamped : n_log_reg;
    assign load_pairs   = CW'(1) << n_cur;
    assign run_pairs    = CW'(1) << n_log_reg;

    assign accept       = (state_reg == LOAD) && bus.in_valid;
    assign load_last    = accept && ((wr_cnt_reg + CW'(1)) == load_pairs);
    assign cms_active   = (state_reg == RUN) || (state_reg == WAIT_DONE);
    assign req          = bus.cms_next_number && !bus.cms_done;
    assign advance      = (state_reg == RUN) && req && (CW'(rd_ptr_reg) < (run_pairs - CW'(1)));
    assign consume_last = (state_reg == RUN) && req && !advance;

    assign rd_en   = load_last || advance;
    assign rd_addr = load_last ? '0 : rd_ptr_reg + AW'(1);
    assign wr_addr = wr_cnt_reg[AW-1:0];
    assign wr_data = {bus.in_y, bus.in_y_hat};

    // Bypass covers the one-pair block, where pair 0 is read on the cycle it is written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= (accept && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:      if (load_last) state_next = RUN;
            RUN: begin
                if (bus.cms_done)      state_next = RESULT;
                else if (consume_last) state_next = WAIT_DONE;
            end
            WAIT_DONE: if (bus.cms_done) state_next = RESULT;
            RESULT:    if (bus.res_ready) state_next = LOAD;
            default:   state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_reg   <= '0;
            rd_ptr_reg   <= '0;
            n_log_reg    <= '0;
            err_reg      <= 1'b0;
            res_data_reg <= '0;
        end else begin
            if (accept) begin
                wr_cnt_reg <= wr_cnt_reg + CW'(1);
            end else if ((state_reg == RESULT) && bus.res_ready) begin
                wr_cnt_reg <= '0;
            end
            if (accept && (wr_cnt_reg == '0)) begin
                n_log_reg <= log2n_clamped;
            end
            if (load_last) begin
                rd_ptr_reg <= '0;
            end else if (advance) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if ((state_reg == WAIT_DONE) && req) begin
                err_reg <= 1'b1;
            end
            if (cms_active && bus.cms_done) begin
                res_data_reg <= bus.cms_result;
            end
        end
    end

    assign bus.in_ready  = (state_reg == LOAD);
    assign bus.cms_start = cms_active;
    assign bus.cms_log2n = n_log_reg;
    // The read register holds stale data in LOAD, so the pair outputs are forced to zero there.
    assign bus.cms_y     = (state_reg != LOAD) ? rd_data_reg[2*DATA_W-1:DATA_W] : '0;
    assign bus.cms_y_hat = (state_reg != LOAD) ? rd_data_reg[DATA_W-1:0] : '0;
    assign bus.res_valid = (state_reg == RESULT);
    assign bus.res_data  = res_data_reg;
    assign bus.busy      = !((state_reg == LOAD) && (wr_cnt_reg == '0));
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_cms_sample_feeder.sv
// Directed bench for cms_sample_feeder: stimulus queues expected pairs, exponents
// and results; a negedge monitor pops and compares them as the DUT presents them.
module tb_cms_sample_feeder;
    localparam int DATA_W    = 32;
    localparam int MAX_LOG2N = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cms_sample_feeder_if #(.DATA_W(DATA_W)) bus ();

    cms_sample_feeder #(.MAX_LOG2N(MAX_LOG2N), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2*DATA_W-1:0] exp_pair_q [$];
    logic [63:0]         exp_res_q  [$];
    logic [2:0]          exp_log_q  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected nothing queued", name, act);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    logic prev_start = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_start = 1'b0;
            end else begin
                if (bus.cms_start && !prev_start) begin
                    if (exp_log_q.size() == 0) unexpected("cms_log2n", 64'(bus.cms_log2n));
                    else check("cms_log2n", 64'(bus.cms_log2n), 64'(exp_log_q.pop_front()));
                end
                if (bus.cms_start && bus.cms_next_number) begin
                    if (exp_pair_q.size() == 0) unexpected("cms_pair", 64'({bus.cms_y, bus.cms_y_hat}));
                    else check("cms_pair", 64'({bus.cms_y, bus.cms_y_hat}), 64'(exp_pair_q.pop_front()));
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_res_q.size() == 0) unexpected("res_data", bus.res_data);
                    else check("res_data", bus.res_data, exp_res_q.pop_front());
                end
                prev_start = bus.cms_start;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and returns one tick after it is accepted; in_valid is left high.
    task automatic write_pair(input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] yh, input logic [2:0] l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_y     = y;
        bus.in_y_hat = yh;
        bus.log2n    = l;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) unexpected("in_ready_timeout", 64'(bus.in_ready));
        tick();
        exp_pair_q.push_back({y, yh});
    endtask

    task automatic next_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.cms_next_number = 1'b1;
            tick();
            bus.cms_next_number = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic give_done(input logic [63:0] r, input logic with_next);
        bus.cms_result      = r;
        bus.cms_done        = 1'b1;
        bus.cms_next_number = with_next;
        exp_res_q.push_back(r);
        tick();
        bus.cms_done        = 1'b0;
        bus.cms_next_number = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int c0;
        bus.log2n = 3'd0;       bus.in_valid = 1'b0;
        bus.in_y = '0;          bus.in_y_hat = '0;
        bus.cms_next_number = 1'b0;
        bus.cms_done = 1'b0;    bus.cms_result = '0;
        bus.res_ready = 1'b1;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cms_start", 64'(bus.cms_start), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_res_data", bus.res_data, 64'd0);
        check("rst_cms_y", 64'(bus.cms_y), 64'd0);
        check("rst_cms_log2n", 64'(bus.cms_log2n), 64'd0);
        tick();

        // Reset mid-stream: 3 of 8 pairs, then abort
        for (int k = 0; k < 3; k++) write_pair(32'(k + 100), 32'(k + 200), 3'd3);
        bus.in_valid = 1'b0;
        check("partial_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        exp_pair_q.delete();
        #2;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_cms_start", 64'(bus.cms_start), 64'd0);
        check("abort_res_valid", 64'(bus.res_valid), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Basic block, N=8, then result backpressure
        exp_log_q.push_back(3'd3);
        c0 = cyc;
        for (int k = 0; k < 8; k++) write_pair(32'(k), 32'(k + 5), 3'd3);
        bus.in_valid = 1'b0;
        check("load_cycles", 64'(cyc - c0), 64'd8);
        @(negedge clk);
        check("run_cms_start", 64'(bus.cms_start), 64'd1);
        check("run_in_ready", 64'(bus.in_ready), 64'd0);
        check("run_first_y", 64'(bus.cms_y), 64'd0);
        check("run_first_y_hat", 64'(bus.cms_y_hat), 64'd5);
        tick();
        next_pulses(8, 0);
        @(negedge clk);
        check("basic_err", 64'(bus.err), 64'd0);
        check("wait_cms_y_last", 64'(bus.cms_y), 64'd7);
        tick();
        bus.res_ready = 1'b0;
        give_done(64'd200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", 64'(bus.res_valid), 64'd1);
            check("bp_res_data", bus.res_data, 64'd200);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        @(negedge clk);
        check("handoff_res_valid", 64'(bus.res_valid), 64'd0);
        check("handoff_in_ready", 64'(bus.in_ready), 64'd1);
        check("handoff_busy", 64'(bus.busy), 64'd0);
        tick();

        // Gapped input, log2n changes after the first write
        exp_log_q.push_back(3'd2);
        write_pair(32'h10, 32'h20, 3'd2);
        for (int k = 1; k < 4; k++) begin
            bus.in_valid = 1'b0;
            tick();
            write_pair(32'(16 + k), 32'(32 + k), 3'd5);
        end
        bus.in_y = 32'h99; bus.in_y_hat = 32'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_no_5th_accept", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        next_pulses(4, 1);
        give_done(64'h1234_5678_9abc_def0, 1'b0);
        @(negedge clk);
        check("gap_res_valid", 64'(bus.res_valid), 64'd1);
        check("gap_err", 64'(bus.err), 64'd0);
        tick();

        // N=1 block with one request too many
        exp_log_q.push_back(3'd0);
        write_pair(32'hAAAA_0001, 32'hBBBB_0001, 3'd0);
        bus.in_valid = 1'b0;
        next_pulses(1, 0);
        @(negedge clk);
        check("n1_err_before", 64'(bus.err), 64'd0);
        tick();
        exp_pair_q.push_back({32'hAAAA_0001, 32'hBBBB_0001});
        next_pulses(1, 0);
        @(negedge clk);
        check("n1_err_after", 64'(bus.err), 64'd1);
        tick();
        give_done(64'd77, 1'b0);
        tick();

        // done together with next_number: no advance, straight to RESULT
        exp_log_q.push_back(3'd2);
        for (int k = 0; k < 4; k++) write_pair(32'(300 + k), 32'(400 + k), 3'd2);
        bus.in_valid = 1'b0;
        give_done(64'd55, 1'b1);
        @(negedge clk);
        check("dn_res_valid", 64'(bus.res_valid), 64'd1);
        check("dn_cms_y_held", 64'(bus.cms_y), 64'd300);
        check("dn_cms_y_hat_held", 64'(bus.cms_y_hat), 64'd400);
        check("dn_err_sticky", 64'(bus.err), 64'd1);
        check("dn_unconsumed", 64'(exp_pair_q.size()), 64'd3);
        exp_pair_q.delete();
        tick();
        tick();

        check("pending_results", 64'(exp_res_q.size()), 64'd0);
        check("pending_log2n", 64'(exp_log_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cms_sample_feeder.md
Name: cms_sample_feeder

Overview:
- Upstream stage of ComplexMeanSquare.
- Collects a block of 2^log2n complex sample pairs (y, y_hat) from a streaming valid/ready source into an internal buffer, then drives the CMS start/next_number/done protocol, presenting one pair per next_number request.
- Captures the 64-bit CMS result and offers it downstream on a valid/ready port.
- Buffers one block at a time; a new block can be loaded only after the result has been handed off.

Parameters:
- MAX_LOG2N, 7, largest supported log2n; buffer depth is 2^MAX_LOG2N pairs.
- DATA_W, 32, width of y and y_hat; packed complex, real in [DATA_W-1:DATA_W/2], imag in [DATA_W/2-1:0]. The feeder treats the data as opaque.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- log2n  in  3  block size exponent; sampled on the first accepted write of a block.
- in_valid  in  1  source has a pair.
- in_ready  out  1  feeder accepts a pair this cycle.
- in_y  in  DATA_W  reference sample.
- in_y_hat  in  DATA_W  estimated sample.
- cms_start  out  1  to CMS start.
- cms_log2n  out  3  latched block exponent to CMS.
- cms_y  out  DATA_W  current pair, y.
- cms_y_hat  out  DATA_W  current pair, y_hat.
- cms_next_number  in  1  CMS requests the next pair.
- cms_done  in  1  CMS result valid.
- cms_result  in  64  CMS result.
- res_valid  out  1  result available downstream.
- res_ready  in  1  downstream accepts the result.
- res_data  out  64  captured result.
- busy  out  1  high in every state except LOAD with wr_cnt==0.
- err  out  1  sticky: more than N next_number requests in one block.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=LOAD, wr_cnt=0, rd_ptr=0, err=0, res_data=0. All outputs are 0 except in_ready, which is 1. Buffer contents are don't-care.
- Reset asserted mid-operation aborts the block. No result is produced and partial buffer contents are discarded.
- States: LOAD -> RUN -> WAIT_DONE -> RESULT -> LOAD.
- LOAD:
  - in_ready=1.
  - Accept on in_valid & in_ready, writing buffer[wr_cnt] and incrementing wr_cnt.
  - On the first accept (wr_cnt==0), latch N_log=log2n. Later log2n changes are ignored until the next block.
  - log2n > MAX_LOG2N is clamped to MAX_LOG2N.
  - On the accept that makes wr_cnt==2^N_log, go to RUN next cycle. in_ready drops that same next cycle.
- RUN:
  - cms_start=1 from entry and held high through WAIT_DONE.
  - On entry, cms_y/cms_y_hat are registered from buffer[0] and rd_ptr=0.
  - At each rising edge with cms_next_number=1 and rd_ptr < 2^N_log-1: rd_ptr++ and the outputs load buffer[rd_ptr+1]. The new pair is visible the cycle after the request.
  - The request that consumes the last pair moves the feeder to WAIT_DONE.
- WAIT_DONE:
  - Outputs hold the last pair.
  - Any further cms_next_number sets err=1 and is otherwise ignored.
- cms_done=1 in RUN or WAIT_DONE:
  - res_data<=cms_result, cms_start<=0, go to RESULT.
  - cms_done takes priority over a simultaneous cms_next_number, which is ignored.
- RESULT:
  - res_valid=1 and res_data stable until res_valid & res_ready.
  - On handoff: wr_cnt=0, go to LOAD, in_ready=1 the next cycle.
  - in_ready=0 throughout RESULT.
- cms_log2n = N_log, registered, stable from RUN through RESULT.
- err is cleared only by reset.
- Latency: full block stored to cms_start=1 is 1 cycle. cms_done to res_valid is 1 cycle.
- Block with N=1 (log2n=0): the single write leads to RUN. The first next_number moves to WAIT_DONE and a second one sets err.

Test Plan:
- Reset mid-stream: load 3 of 8 pairs, pulse reset low -> in_ready=1, busy=0, cms_start=0, res_valid=0. A fresh 8-pair block then runs normally.
- Basic block: log2n=3; write pairs y=k, y_hat=k+5 for k=0..7 with in_valid held high -> in_ready high for 8 cycles; cms_start rises 1 cycle later with cms_log2n=3, cms_y=0, cms_y_hat=5. A CMS model pulsing next_number sees y=1..7 in order. Model returns done with result=200 -> res_valid the next cycle, res_data=200.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stays 200 and in_ready stays 0. Raise res_ready -> res_valid drops and in_ready=1 the next cycle.
- Gapped input plus log2n change: log2n=2 at the first write, then log2n=5 with in_valid toggling every other cycle -> exactly 4 pairs accepted and cms_log2n=2.
- Protocol edges: N=1 block with 2 next_number pulses -> err=1. Done asserted on the same edge as next_number -> the feeder goes to RESULT and rd_ptr does not advance.
